// File: rtl/sram_mem_ctrl_pkg.sv
// Shared constants, FSM encoding and request payload for the SRAM data-memory controller.
package sram_mem_ctrl_pkg;

    localparam int unsigned ADDRESS_LEN   = 32;
    localparam int unsigned REGISTER_LEN  = 32;
    localparam int unsigned SRAM_ADDR_LEN = 18;
    localparam int unsigned SRAM_DATA_LEN = 16;
    localparam int unsigned WORD_IDX_LEN  = SRAM_ADDR_LEN - 1;

    localparam logic [ADDRESS_LEN-1:0] DATA_MEM_BASE = ADDRESS_LEN'(1024);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACC_LO = 2'd1,
        ST_ACC_HI = 2'd2,
        ST_DONE   = 2'd3
    } sram_state_e;

    typedef struct packed {
        logic                    is_write;
        logic [WORD_IDX_LEN-1:0] word;
        logic [REGISTER_LEN-1:0] wdata;
    } sram_req_t;

    // Word index inside data memory: offset from the base, byte address bits [18:2].
    function automatic logic [WORD_IDX_LEN-1:0] word_of(
        input logic [ADDRESS_LEN-1:0] address,
        input logic [ADDRESS_LEN-1:0] base
    );
        logic [ADDRESS_LEN-1:0] eff;
        eff = address - base;
        return eff[18:2];
    endfunction

endpackage

// File: rtl/sram_mem_ctrl_phase_counter.sv
// Wait-state counter for one half-word SRAM access; last flags the final cycle.
module sram_phase_counter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int unsigned CNT_W = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] LAST_VAL = CNT_W'(ACCESS_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign last = (cnt == LAST_VAL);

    // Count 0..ACCESS_CYCLES-1 while enabled, wrapping so the next phase starts at 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// 32-bit MEM-stage to 16-bit async SRAM controller: each word is two half-word
// accesses with programmable wait states. Optional one-entry read cache is
// enabled by defining SRAM_READ_CACHE_EN.
module sram_mem_ctrl
    import sram_mem_ctrl_pkg::*;
#(
    parameter logic [ADDRESS_LEN-1:0] BASE_ADDR     = DATA_MEM_BASE,
    parameter int unsigned            ACCESS_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rd_en,
    input  logic                     wr_en,
    input  logic [ADDRESS_LEN-1:0]   address,
    input  logic [REGISTER_LEN-1:0]  write_data,
    output logic [REGISTER_LEN-1:0]  read_data,
    output logic                     ready,
    inout  wire  [SRAM_DATA_LEN-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_LEN-1:0] SRAM_ADDR,
    output logic                     SRAM_WE_N,
    output logic                     SRAM_OE_N,
    output logic                     SRAM_CE_N,
    output logic                     SRAM_UB_N,
    output logic                     SRAM_LB_N
);

    sram_state_e              state_q, state_d;
    sram_req_t                req_q;
    logic [REGISTER_LEN-1:0]  rdata_q;
    logic [SRAM_ADDR_LEN-1:0] sram_addr_q;
    logic [WORD_IDX_LEN-1:0]  req_word;
    logic [SRAM_DATA_LEN-1:0] dq_out;
    logic                     dq_en;
    logic                     req_any;
    logic                     in_acc;
    logic                     phase_last;
    logic                     start;
    logic                     cache_hit_c;
    logic [REGISTER_LEN-1:0]  cache_data_c;

    assign req_any   = rd_en | wr_en;
    assign req_word  = word_of(address, BASE_ADDR);
    assign in_acc    = (state_q == ST_ACC_LO) || (state_q == ST_ACC_HI);
    assign start     = (state_q == ST_IDLE) && req_any && !cache_hit_c;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = dq_en ? dq_out : {SRAM_DATA_LEN{1'bz}};

    sram_phase_counter #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_phase_counter (
        .clk    (clk),
        .rst    (rst),
        .clear  (!in_acc),
        .enable (in_acc),
        .last   (phase_last)
    );

`ifdef SRAM_READ_CACHE_EN
    logic                    cache_valid_q;
    logic [WORD_IDX_LEN-1:0] cache_word_q;
    logic [REGISTER_LEN-1:0] cache_data_q;

    assign cache_hit_c  = (state_q == ST_IDLE) && rd_en && !wr_en && cache_valid_q
                          && (cache_word_q == req_word);
    assign cache_data_c = cache_data_q;
    assign read_data    = cache_hit_c ? cache_data_q : rdata_q;

    // Completed reads fill the entry; completed writes to the cached word refresh it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cache_valid_q <= 1'b0;
            cache_word_q  <= '0;
            cache_data_q  <= '0;
        end else if ((state_q == ST_ACC_HI) && phase_last) begin
            if (!req_q.is_write) begin
                cache_valid_q <= 1'b1;
                cache_word_q  <= req_q.word;
                cache_data_q  <= {SRAM_DQ, rdata_q[SRAM_DATA_LEN-1:0]};
            end else if (cache_valid_q && (cache_word_q == req_q.word)) begin
                cache_data_q  <= req_q.wdata;
            end
        end
    end
`else
    assign cache_hit_c  = 1'b0;
    assign cache_data_c = '0;
    assign read_data    = rdata_q;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request latch, SRAM address and read-data capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            req_q       <= '0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
        end else begin
            if (start) begin
                req_q.is_write <= wr_en;
                req_q.word     <= req_word;
                req_q.wdata    <= write_data;
                sram_addr_q    <= {req_word, 1'b0};
            end
            if ((state_q == ST_ACC_LO) && phase_last) begin
                sram_addr_q <= {req_q.word, 1'b1};
            end
            if (in_acc && phase_last && !req_q.is_write) begin
                if (state_q == ST_ACC_LO) begin
                    rdata_q[SRAM_DATA_LEN-1:0] <= SRAM_DQ;
                end else begin
                    rdata_q[REGISTER_LEN-1:SRAM_DATA_LEN] <= SRAM_DQ;
                end
            end
            if (cache_hit_c) begin
                rdata_q <= cache_data_c;
            end
        end
    end

    // Next state, handshake and SRAM strobes.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        SRAM_WE_N = 1'b1;
        SRAM_OE_N = 1'b1;
        dq_en     = 1'b0;
        dq_out    = (state_q == ST_ACC_HI) ? req_q.wdata[REGISTER_LEN-1:SRAM_DATA_LEN]
                                           : req_q.wdata[SRAM_DATA_LEN-1:0];
        case (state_q)
            ST_IDLE: begin
                ready = !req_any || cache_hit_c;
                if (start) begin
                    state_d = ST_ACC_LO;
                end
            end
            ST_ACC_LO, ST_ACC_HI: begin
                if (req_q.is_write) begin
                    dq_en     = 1'b1;
                    SRAM_WE_N = phase_last;
                end else begin
                    SRAM_OE_N = 1'b0;
                end
                if (phase_last) begin
                    state_d = (state_q == ST_ACC_LO) ? ST_ACC_HI : ST_DONE;
                end
            end
            ST_DONE: begin
                ready   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
